// File: rtl/midi_cmd_encoder.sv
// MIDI byte-stream parser producing 16-bit note start/stop command words
// {cmd, note[6:0], vel[7:0]} through a small valid/ready output FIFO.
module midi_cmd_encoder #(
  parameter bit          CHAN_FILTER_EN = 1'b0,
  parameter logic [3:0]  CHANNEL        = 4'd0,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  i_byte,
  input  logic                        i_byte_valid,
  output logic [15:0]                 o_data,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic                        o_overflow,
  output logic [$clog2(FIFO_DEPTH):0] o_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2} state_t;

  state_t      state, state_next;
  logic [7:0]  status, status_next;
  logic [6:0]  note, note_next;
  logic        push;
  logic [15:0] push_word;
  logic [7:0]  vel;
  logic        is_syscommon, is_chan_status, is_data;
  logic        chan_ok, note_msg, one_byte_msg;

  // Realtime bytes (0xF8-0xFF) match none of these classes and fall through untouched.
  assign is_syscommon   = i_byte[7:3] == 5'b11110;
  assign is_chan_status = i_byte[7] && (i_byte[7:4] != 4'hF);
  assign is_data        = !i_byte[7];
  assign chan_ok        = !CHAN_FILTER_EN || (status[3:0] == CHANNEL);
  assign note_msg       = status[7:5] == 3'b100;
  assign one_byte_msg   = status[7:5] == 3'b110;
  assign vel            = {1'b0, i_byte[6:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      status <= '0;
      note   <= '0;
    end else begin
      state  <= state_next;
      status <= status_next;
      note   <= note_next;
    end
  end

  always_comb begin
    state_next  = state;
    status_next = status;
    note_next   = note;
    push        = 1'b0;
    push_word   = '0;
    if (i_byte_valid) begin
      if (is_chan_status) begin
        status_next = i_byte;
        state_next  = WAIT_D1;
      end else if (is_syscommon) begin
        status_next = '0;
        state_next  = IDLE;
      end else if (is_data) begin
        case (state)
          WAIT_D1: begin
            note_next = i_byte[6:0];
            if (!one_byte_msg) state_next = WAIT_D2;
          end
          WAIT_D2: begin
            state_next = WAIT_D1;
            push       = note_msg && chan_ok;
            // Note-on with zero velocity and note-off both encode as stop.
            push_word  = {status[4] && (vel != '0), note, vel};
          end
          default: ;
        endcase
      end
    end
  end

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          pop, full, accept;

  assign pop    = o_valid && i_ready;
  assign full   = count == FULL_COUNT;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign accept = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !accept) o_overflow <= 1'b1;
    end
  end

  assign o_valid = count != '0;
  assign o_data  = o_valid ? mem[rd_ptr] : '0;
  assign o_count = count;

endmodule

// File: tb/tb_midi_cmd_encoder.sv
// Bench for midi_cmd_encoder: an unfiltered and a channel-2 filtered instance
// share one byte stream and are checked against a queue-based reference model.
module tb_midi_cmd_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        ready;

  logic [15:0] u_data, f_data;
  logic        u_valid, f_valid, u_ovf, f_ovf;
  logic [2:0]  u_count, f_count;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int rs;
  int nd;
  int d0, d1;
  int fq0[$];
  int fq1[$];
  bit ov0, ov1;

  always #5 clk = ~clk;

  midi_cmd_encoder #(.CHAN_FILTER_EN(1'b0), .CHANNEL(4'd0), .FIFO_DEPTH(4)) dut_u (
    .clk(clk), .reset(reset), .i_byte(byte_in), .i_byte_valid(byte_valid),
    .o_data(u_data), .o_valid(u_valid), .i_ready(ready),
    .o_overflow(u_ovf), .o_count(u_count)
  );

  midi_cmd_encoder #(.CHAN_FILTER_EN(1'b1), .CHANNEL(4'd2), .FIFO_DEPTH(4)) dut_f (
    .clk(clk), .reset(reset), .i_byte(byte_in), .i_byte_valid(byte_valid),
    .o_data(f_data), .o_valid(f_valid), .i_ready(ready),
    .o_overflow(f_ovf), .o_count(f_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    rs = -1;
    nd = 0;
    fq0.delete();
    fq1.delete();
    ov0 = 1'b0;
    ov1 = 1'b0;
  endtask

  task automatic model_edge(input logic [7:0] b, input bit v, input bit rdy);
    bit have;
    int word, ch, hi, len;
    have = 1'b0;
    word = 0;
    ch   = 0;
    if (v && b < 8'hF8) begin
      if (b >= 8'hF0) begin
        rs = -1;
        nd = 0;
      end else if (b >= 8'h80) begin
        rs = int'(b);
        nd = 0;
      end else if (rs >= 0) begin
        hi  = rs / 16;
        len = (hi == 12 || hi == 13) ? 1 : 2;
        if (nd == 0) d0 = int'(b); else d1 = int'(b);
        nd++;
        if (nd == len) begin
          nd = 0;
          if (hi == 8 || hi == 9) begin
            have = 1'b1;
            word = ((hi == 9 && d1 != 0) ? 32768 : 0) + d0 * 256 + d1;
            ch   = rs % 16;
          end
        end
      end
    end
    if (rdy && fq0.size() > 0) void'(fq0.pop_front());
    if (rdy && fq1.size() > 0) void'(fq1.pop_front());
    if (have) begin
      if (fq0.size() < 4) fq0.push_back(word); else ov0 = 1'b1;
      if (ch == 2) begin
        if (fq1.size() < 4) fq1.push_back(word); else ov1 = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string where);
    check({where, " u.valid"}, 32'(u_valid), 32'(fq0.size() > 0));
    check({where, " u.data"},  32'(u_data),  32'((fq0.size() > 0) ? fq0[0] : 0));
    check({where, " u.count"}, 32'(u_count), 32'(fq0.size()));
    check({where, " u.ovf"},   32'(u_ovf),   32'(ov0));
    check({where, " f.valid"}, 32'(f_valid), 32'(fq1.size() > 0));
    check({where, " f.data"},  32'(f_data),  32'((fq1.size() > 0) ? fq1[0] : 0));
    check({where, " f.count"}, 32'(f_count), 32'(fq1.size()));
    check({where, " f.ovf"},   32'(f_ovf),   32'(ov1));
  endtask

  task automatic step(input logic [7:0] b, input bit v, input bit rdy, input string where);
    byte_in    = b;
    byte_valid = v;
    ready      = rdy;
    @(posedge clk);
    model_edge(b, v, rdy);
    #1;
    check_all(where);
  endtask

  task automatic send(input logic [7:0] b, input string where);
    step(b, 1'b1, 1'b0, where);
  endtask

  task automatic pop1(input string where);
    step(8'h00, 1'b0, 1'b1, where);
  endtask

  initial begin
    logic [7:0] rb;
    bit rv, rr;
    int r;

    reset      = 1'b1;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    ready      = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    check("reset u.data const", 32'(u_data), 32'h0);
    reset = 1'b0;

    // Basic note-on and pop
    send(8'h90, "basic"); send(8'h3C, "basic"); send(8'h64, "basic");
    check("basic u.data const", 32'(u_data), 32'h0000BC64);
    check("basic u.count const", 32'(u_count), 32'd1);
    pop1("basic pop");
    check("basic pop u.valid const", 32'(u_valid), 32'd0);

    // Running status and velocity-zero mapping
    send(8'h90, "run"); send(8'h40, "run"); send(8'h7F, "run");
    send(8'h40, "run"); send(8'h00, "run");
    send(8'h80, "run"); send(8'h40, "run"); send(8'h20, "run");
    check("run head const", 32'(u_data), 32'h0000C07F);
    pop1("run pop");
    check("run vel0 const", 32'(u_data), 32'h00004000);
    pop1("run pop");
    check("run noteoff const", 32'(u_data), 32'h00004020);
    pop1("run pop");

    // Realtime transparency and ignored messages
    send(8'h90, "ign"); send(8'h3C, "ign"); send(8'hF8, "ign"); send(8'h50, "ign");
    send(8'hB0, "ign"); send(8'h07, "ign"); send(8'h64, "ign");
    send(8'hC0, "ign"); send(8'h05, "ign"); send(8'h06, "ign");
    send(8'hF0, "ign"); send(8'h3C, "ign"); send(8'h10, "ign");
    check("ign count const", 32'(u_count), 32'd1);
    check("ign head const", 32'(u_data), 32'h0000BC50);
    pop1("ign pop");

    // Aborted message
    send(8'h90, "abort"); send(8'h3C, "abort"); send(8'h80, "abort");
    send(8'h3E, "abort"); send(8'h11, "abort");
    check("abort head const", 32'(u_data), 32'h00003E11);
    check("abort count const", 32'(u_count), 32'd1);
    pop1("abort pop");

    // Channel filter
    send(8'h91, "filt"); send(8'h3C, "filt"); send(8'h40, "filt");
    send(8'h92, "filt"); send(8'h3C, "filt"); send(8'h40, "filt");
    check("filt f.count const", 32'(f_count), 32'd1);
    check("filt f.data const", 32'(f_data), 32'h0000BC40);
    check("filt u.count const", 32'(u_count), 32'd2);
    pop1("filt pop"); pop1("filt pop");

    // Fill to full, then overflow
    send(8'h92, "full");
    for (int i = 0; i < 5; i++) begin
      send(8'h30 + 8'(i), "full");
      send(8'h40 + 8'(i), "full");
    end
    check("full count const", 32'(u_count), 32'd4);
    check("full ovf const", 32'(u_ovf), 32'd1);
    check("full head const", 32'(u_data), 32'h0000B040);
    send(8'h35, "pushpop");
    step(8'h45, 1'b1, 1'b1, "pushpop");
    check("pushpop count const", 32'(u_count), 32'd4);
    pop1("drain"); pop1("drain"); pop1("drain");
    check("pushpop word const", 32'(u_data), 32'h0000B545);

    // Reset mid-message with words queued
    send(8'h36, "prerst"); send(8'h46, "prerst"); send(8'h37, "prerst");
    reset      = 1'b1;
    byte_valid = 1'b0;
    #2;
    model_reset();
    check_all("async reset");
    check("async reset ovf const", 32'(u_ovf), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    send(8'h50, "postrst"); send(8'h60, "postrst");
    check("postrst count const", 32'(u_count), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      r  = int'($urandom_range(0, 99));
      rv = 1'b1;
      if (r < 35)      rb = 8'($urandom_range(0, 127));
      else if (r < 50) rb = {($urandom_range(0, 1) != 0) ? 4'h9 : 4'h8, 4'($urandom_range(0, 3))};
      else if (r < 57) rb = 8'($urandom_range(8'hA0, 8'hEF));
      else if (r < 62) rb = 8'($urandom_range(8'hF8, 8'hFF));
      else if (r < 65) rb = 8'($urandom_range(8'hF0, 8'hF7));
      else begin
        rb = 8'($urandom_range(0, 255));
        rv = 1'b0;
      end
      rr = ($urandom_range(0, 2) == 0);
      step(rb, rv, rr, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/midi_cmd_encoder.md
# midi_cmd_encoder

Converts a raw MIDI byte stream (one byte per strobe, from the UART receiver) into the 16-bit note command words consumed by the synthesizer voice manager: bit 15 = command (1 start, 0 stop), bits 14:8 = MIDI note, bits 7:0 = velocity. It is the producer end of that command interface. It parses status and data bytes with running status, filters channels, maps note-on with velocity 0 to stop, and buffers encoded words in a small FIFO behind a valid/ready handshake.

## Interface
- CHAN_FILTER_EN, 0, 1 = emit only messages on channel CHANNEL; 0 = accept all 16 channels
- CHANNEL, 0, MIDI channel nibble 0–15 used when filtering
- FIFO_DEPTH, 4, output FIFO depth in words; power of two, ≥2
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- i_byte  in  8  MIDI byte, valid only with i_byte_valid
- i_byte_valid  in  1  one-cycle strobe; at most one byte per cycle
- o_data  out  16  head of FIFO: {cmd, note[6:0], vel[7:0]}; 16'h0000 when empty
- o_valid  out  1  FIFO non-empty
- i_ready  in  1  consumer accepts head; pop occurs on edge where o_valid && i_ready
- o_overflow  out  1  sticky; set when a completed word is dropped because FIFO full; cleared only by reset
- o_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Byte classes: bit7=1 status, bit7=0 data.
- Realtime bytes 0xF8–0xFF: ignored completely; they change neither state nor running status, even mid-message.
- System common 0xF0–0xF7: clear running status, go IDLE; following data bytes ignored until next channel status.
- Channel status 0x80–0xEF: latch as running status, go WAIT_D1, discarding any partial message.
- States: IDLE (no running status; data bytes dropped), WAIT_D1, WAIT_D2.
- WAIT_D1 + data: latch note = byte[6:0]. For 0xC_/0xD_ (one-data-byte messages), message complete, stay WAIT_D1. Otherwise go WAIT_D2.
- WAIT_D2 + data: latch vel = byte[6:0] zero-extended to 8 bits. Message complete, return to WAIT_D1 (running status retained).
- Completed message emits a word only when all of these hold:
  - status is 0x8_ or 0x9_;
  - the channel passes the filter.
- Other complete messages (0xA_, 0xB_, 0xC_, 0xD_, 0xE_) are parsed and discarded.
- Encoding:
  - 0x9_ with vel≠0 → {1, note, vel}.
  - 0x9_ with vel=0 → {0, note, 8'h00}.
  - 0x8_ → {0, note, vel} (release velocity carried; the consumer ignores it).
- FIFO push on completion; drop the word and set o_overflow if full, unless a pop occurs on the same edge (then the push is accepted).
- Order preserved; no coalescing of duplicate notes.

## Timing
- Reset:
  - state = IDLE, running status cleared;
  - FIFO empty: o_valid=0, o_data=16'h0000, o_count=0;
  - o_overflow=0.
- Reset mid-message discards the partial message and all queued words.
- Latency: the final data byte is sampled at edge k. The word is visible on o_data/o_valid after edge k (one cycle) when the FIFO was empty.
- Pop at edge k: the next head (or 0/empty) is visible after edge k. o_data is registered and stable while o_valid && !i_ready.
- Simultaneous push and pop: count unchanged; a push into an empty FIFO with i_ready=1 is not bypassed (valid for ≥1 cycle).
- Pointers wrap modulo FIFO_DEPTH; full when o_count == FIFO_DEPTH.
- Throughput: one word per cycle in and out.
- i_ready tied 1 yields one-cycle o_valid pulses.

## Test plan
- Basic note-on: bytes 0x90,0x3C,0x64 → one word 16'hBC64 one cycle after the third strobe; o_count=1. Pop with i_ready=1 → o_valid=0, o_data=0.
- Running status and velocity-zero mapping: 0x90,0x40,0x7F,0x40,0x00 → words 16'hC07F then 16'h4000. A further 0x80,0x40,0x20 → 16'h4020.
- Interleaved and ignored traffic: 0x90,0x3C,0xF8,0x50 → 16'hBC50 (realtime is transparent). Then 0xB0,0x07,0x64 → no word. Then 0xC0,0x05,0x06 → no word. Then 0xF0 followed by 0x3C,0x10 → no word.
- Aborted message: 0x90,0x3C,0x80,0x3E,0x11 → only 16'h3E11.
- Channel filter with CHAN_FILTER_EN=1, CHANNEL=2: 0x91,0x3C,0x40 → no word. 0x92,0x3C,0x40 → 16'hBC40.
- Full and overflow with FIFO_DEPTH=4, i_ready=0:
  - five note-ons → o_count=4, o_overflow=1, head is the first word;
  - then, with the FIFO full, complete a sixth message on the same edge as a pop (i_ready=1) → o_count stays 4, word accepted;
  - assert reset mid-message → all outputs return to their reset values.
